// File: rtl/life_rule_engine.sv
// rtl/life_rule_engine.sv - B3/S23 next-generation engine for one field row
// Consumes column-serial 3-bit slices and emits packed 16-bit result words with DDR addresses.
module life_rule_engine #(
  parameter int ROW_WIDTH = 640,
  parameter int WORD_BITS = 16,
  parameter int ROW_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_BITS-1:0]  rowIndex,
  input  logic                 inValid,
  input  logic [2:0]           inSlice,
  output logic                 inReady,
  output logic                 outValid,
  output logic [WORD_BITS-1:0] outData,
  output logic [23:0]          outAddress,
  input  logic                 outReady,
  output logic                 rowDone,
  output logic [9:0]           liveCount,
  output logic                 busy
);

  localparam int COL_W  = $clog2(ROW_WIDTH + 1);
  localparam int WB_LOG = $clog2(WORD_BITS);
  localparam int PAD_W  = 24 - ROW_BITS - 6;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t               state;
  logic [ROW_BITS-1:0]  row_q;
  logic [2:0]           win_l;
  logic [2:0]           win_c;
  logic [COL_W-1:0]     col_count;
  logic [WORD_BITS-1:0] pack;
  logic [9:0]           live;

  logic                 out_free;
  logic                 accept;
  logic                 flush_go;
  logic                 decide;
  logic [2:0]           win_r;
  logic [COL_W-1:0]     dcol;
  logic [WB_LOG-1:0]    bit_idx;
  logic [5:0]           word_idx;
  logic [3:0]           n;
  logic                 next_bit;
  logic [WORD_BITS-1:0] pack_next;

  function automatic logic [3:0] col_sum(input logic [2:0] x);
    return {3'b000, x[0]} + {3'b000, x[1]} + {3'b000, x[2]};
  endfunction

  assign out_free = !outValid || outReady;
  assign inReady  = (state == RUN) && out_free;
  assign accept   = inValid && inReady;
  assign flush_go = (state == FLUSH) && out_free;

  // A slice for column k settles cell k-1; column 0 has no left-hand cell to settle.
  assign decide   = (accept && (col_count != '0)) || flush_go;
  assign win_r    = flush_go ? 3'b000 : inSlice;
  assign dcol     = col_count - 1'b1;
  assign bit_idx  = dcol[WB_LOG-1:0];
  assign word_idx = dcol[WB_LOG +: 6];

  assign n         = col_sum(win_l) + col_sum(win_c) + col_sum(win_r) - {3'b000, win_c[1]};
  assign next_bit  = (n == 4'd3) || (win_c[1] && (n == 4'd2));
  assign pack_next = pack | (WORD_BITS'(next_bit) << bit_idx);

  assign busy      = (state != IDLE);
  assign rowDone   = (state == DRAIN) && outValid && outReady;
  assign liveCount = live;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_q      <= '0;
      win_l      <= '0;
      win_c      <= '0;
      col_count  <= '0;
      pack       <= '0;
      live       <= '0;
      outValid   <= 1'b0;
      outData    <= '0;
      outAddress <= '0;
    end else begin
      if (outValid && outReady) outValid <= 1'b0;

      if (decide) begin
        live <= live + 10'(next_bit);
        if (bit_idx == WB_LOG'(WORD_BITS - 1)) begin
          outData    <= pack_next;
          outAddress <= {{PAD_W{1'b0}}, row_q, word_idx};
          outValid   <= 1'b1;
          pack       <= '0;
        end else begin
          pack <= pack_next;
        end
      end

      if (accept) begin
        win_l     <= win_c;
        win_c     <= inSlice;
        col_count <= col_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            row_q     <= rowIndex;
            win_l     <= '0;
            win_c     <= '0;
            col_count <= '0;
            pack      <= '0;
            live      <= '0;
          end
        end
        RUN: begin
          if (accept && (col_count == COL_W'(ROW_WIDTH - 1))) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_go) state <= DRAIN;
        end
        DRAIN: begin
          if (outValid && outReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_rule_engine.sv
// tb/tb_life_rule_engine.sv - directed bench for life_rule_engine
// Each row has at most one nonzero word; all expected words and counts are hand-derived constants.
module tb_life_rule_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  rowIndex;
  logic        inValid;
  logic [2:0]  inSlice;
  logic        inReady;
  logic        outValid;
  logic [15:0] outData;
  logic [23:0] outAddress;
  logic        outReady;
  logic        rowDone;
  logic [9:0]  liveCount;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  life_rule_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rowIndex   (rowIndex),
    .inValid    (inValid),
    .inSlice    (inSlice),
    .inReady    (inReady),
    .outValid   (outValid),
    .outData    (outData),
    .outAddress (outAddress),
    .outReady   (outReady),
    .rowDone    (rowDone),
    .liveCount  (liveCount),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // kind 0: all dead, 1: all live, 2: 3'b111 at column pos only
  function automatic logic [2:0] slice_at(input int kind, input int pos, input int col);
    case (kind)
      0:       return 3'b000;
      1:       return 3'b111;
      default: return (col == pos) ? 3'b111 : 3'b000;
    endcase
  endfunction

  task automatic run_row(input int row, input int kind, input int pos, input int exp_idx,
                         input logic [15:0] exp_val, input int exp_live, input int bp,
                         input int restart_col);
    int col = 0;
    int words = 0;
    int dones = 0;
    int cyc = 0;
    int bp_left = 0;
    int tail = 0;
    bit seen = 0;
    logic [15:0] held_d = '0;
    logic [23:0] held_a = '0;
    logic [15:0] exp_d;
    logic [8:0]  row9;
    row9 = row[8:0];
    start = 1'b1;
    rowIndex = row9;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    while (tail < 4 && cyc < 3000) begin
      cyc++;
      start = (col == restart_col);
      rowIndex = start ? 9'd99 : row9;
      if (outValid && !seen) begin
        seen = 1;
        bp_left = bp;
        held_d = outData;
        held_a = outAddress;
      end
      outReady = (bp_left == 0);
      inValid = (col < 640);
      inSlice = slice_at(kind, pos, col);
      #1;
      if (bp_left > 0) begin
        check_eq("bp_in_ready", inReady, 0);
        check_eq("bp_data_hold", outData, held_d);
        check_eq("bp_addr_hold", outAddress, held_a);
        bp_left--;
      end
      if (outValid && outReady) begin
        exp_d = (words == exp_idx) ? exp_val : 16'h0000;
        check_eq($sformatf("row%0d_word%0d_data", row, words), outData, exp_d);
        check_eq($sformatf("row%0d_word%0d_addr", row, words), outAddress,
                 {9'h000, row9, 6'(words)});
        words++;
      end
      if (rowDone) begin
        dones++;
        check_eq("done_on_last_word", words, 40);
        check_eq("live_at_done", liveCount, exp_live);
      end
      if (inValid && inReady) col++;
      if (dones > 0) tail++;
      @(negedge clk);
    end
    start = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    check_eq("row_done_pulses", dones, 1);
    check_eq("cols_accepted", col, 640);
    check_eq("word_count", words, 40);
    check_eq("idle_not_busy", busy, 0);
    check_eq("live_held", liveCount, exp_live);
  endtask

  task automatic reset_mid_row();
    int col = 0;
    int cyc = 0;
    start = 1'b1;
    rowIndex = 9'd5;
    @(negedge clk);
    start = 1'b0;
    outReady = 1'b1;
    while (col < 300 && cyc < 1000) begin
      cyc++;
      inValid = 1'b1;
      inSlice = slice_at(2, 5, col);
      #1;
      if (inValid && inReady) col++;
      @(negedge clk);
    end
    check_eq("pre_rst_cols", col, 300);
    check_eq("pre_rst_live", liveCount, 3);
    rst = 1'b1;
    inValid = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", outValid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_row_done", rowDone, 0);
    check_eq("rst_live", liveCount, 0);
    rst = 1'b0;
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_in_ready", inReady, 0);
    check_eq("post_rst_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rowIndex = '0;
    inValid = 1'b0;
    inSlice = '0;
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_in_ready", inReady, 0);
    check_eq("reset_out_valid", outValid, 0);
    check_eq("reset_out_data", outData, 0);
    check_eq("reset_out_addr", outAddress, 0);
    check_eq("reset_row_done", rowDone, 0);
    check_eq("reset_live", liveCount, 0);
    check_eq("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    run_row(7,  2, 5,   0,  16'h0070, 3, 0,  -1);
    run_row(3,  2, 639, 39, 16'hC000, 2, 0,  -1);
    run_row(12, 1, 0,   -1, 16'h0000, 0, 0,  -1);
    run_row(13, 0, 0,   -1, 16'h0000, 0, 0,  -1);
    run_row(20, 2, 40,  2,  16'h0380, 3, 20, -1);
    run_row(21, 2, 0,   0,  16'h0003, 2, 0,  100);
    reset_mid_row();
    run_row(9,  2, 5,   0,  16'h0070, 3, 0,  -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
